// File: rtl/prio_interrupt_controller.sv
// Priority interrupt controller: edge/level sources, threshold, claim/complete handshake.
// Edge at cycle N pends at N+1 and raises irq_out at N+2; the CPU paces service via claim/complete.
module prio_interrupt_controller #(
    parameter int NUM_IRQ = 8,
    parameter int PRIO_W  = 3,
    parameter int ID_W    = $clog2(NUM_IRQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_IRQ-1:0]        irq_src,
    input  logic [NUM_IRQ-1:0]        irq_en,
    input  logic [NUM_IRQ-1:0]        irq_edge,
    input  logic [NUM_IRQ*PRIO_W-1:0] irq_prio,
    input  logic [PRIO_W-1:0]         threshold,
    input  logic                      claim,
    input  logic                      complete,
    output logic                      irq_out,
    output logic [ID_W-1:0]           irq_id,
    output logic [ID_W-1:0]           active_id,
    output logic                      in_service,
    output logic [NUM_IRQ-1:0]        irq_overflow
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t               state;
    logic [NUM_IRQ-1:0]   src_prev;
    logic [NUM_IRQ-1:0]   pending;
    logic [NUM_IRQ-1:0]   edge_hit;
    logic [NUM_IRQ-1:0]   pend_clr;
    logic [NUM_IRQ-1:0]   eligible;
    logic                 take_claim;
    logic                 any_elig;
    logic [ID_W-1:0]      win_id;
    logic [PRIO_W-1:0]    win_prio;

    assign take_claim = (state == ASSERT) && claim;
    assign edge_hit   = irq_src & ~src_prev;

    // Only the ID being claimed loses its pending bit, and only in edge mode.
    always_comb begin
        pend_clr = '0;
        if (take_claim) begin
            pend_clr[irq_id] = 1'b1;
        end
    end

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            eligible[i] = pending[i] & irq_en[i] &
                          (irq_prio[i*PRIO_W +: PRIO_W] > threshold);
        end
    end

    // Strict '>' while scanning upward keeps the lowest index on priority ties.
    always_comb begin
        any_elig = 1'b0;
        win_id   = '0;
        win_prio = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (eligible[i] && (!any_elig || (irq_prio[i*PRIO_W +: PRIO_W] > win_prio))) begin
                any_elig = 1'b1;
                win_id   = ID_W'(i);
                win_prio = irq_prio[i*PRIO_W +: PRIO_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_prev     <= '0;
            pending      <= '0;
            irq_overflow <= '0;
        end else begin
            src_prev     <= irq_src;
            pending      <= (irq_edge & (edge_hit | (pending & ~pend_clr))) |
                            (~irq_edge & irq_src);
            irq_overflow <= irq_overflow | (irq_edge & edge_hit & pending & ~pend_clr);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            irq_out    <= 1'b0;
            irq_id     <= '0;
            active_id  <= '0;
            in_service <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_elig) begin
                        irq_id  <= win_id;
                        irq_out <= 1'b1;
                        state   <= ASSERT;
                    end
                end
                ASSERT: begin
                    if (claim) begin
                        active_id  <= irq_id;
                        in_service <= 1'b1;
                        irq_out    <= 1'b0;
                        state      <= SERVICE;
                    end else if (!any_elig) begin
                        irq_out <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        irq_id <= win_id;
                    end
                end
                SERVICE: begin
                    irq_out <= 1'b0;
                    if (complete) begin
                        in_service <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    irq_out    <= 1'b0;
                    in_service <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prio_interrupt_controller.sv
// Directed table-driven bench for prio_interrupt_controller (NUM_IRQ=8, PRIO_W=3).
module tb_prio_interrupt_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  irq_src, irq_en, irq_edge;
    logic [23:0] irq_prio;
    logic [2:0]  threshold;
    logic        claim, complete;
    logic        irq_out;
    logic [2:0]  irq_id, active_id;
    logic        in_service;
    logic [7:0]  irq_overflow;

    int checks   = 0;
    int failures = 0;

    prio_interrupt_controller #(.NUM_IRQ(8), .PRIO_W(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_src      (irq_src),
        .irq_en       (irq_en),
        .irq_edge     (irq_edge),
        .irq_prio     (irq_prio),
        .threshold    (threshold),
        .claim        (claim),
        .complete     (complete),
        .irq_out      (irq_out),
        .irq_id       (irq_id),
        .active_id    (active_id),
        .in_service   (in_service),
        .irq_overflow (irq_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [7:0]  src;
        logic [7:0]  edm;
        logic [23:0] prio;
        logic [2:0]  thr;
        logic        cl;
        logic        cp;
        logic        e_out;
        logic [2:0]  e_id;
        logic [2:0]  e_act;
        logic        e_ins;
        logic [7:0]  e_ovf;
    } vec_t;

    vec_t vq[$];

    function automatic logic [23:0] pr(input int s, input int p);
        return 24'(p) << (3 * s);
    endfunction

    task automatic add(input string n, input logic [7:0] src, input logic [7:0] edm,
                       input logic [23:0] prio, input int thr, input logic cl, input logic cp,
                       input logic eo, input int eid, input int eact, input logic eins,
                       input logic [7:0] eovf);
        vec_t v;
        v.name = n; v.src = src; v.edm = edm; v.prio = prio; v.thr = 3'(thr);
        v.cl = cl; v.cp = cp; v.e_out = eo; v.e_id = 3'(eid); v.e_act = 3'(eact);
        v.e_ins = eins; v.e_ovf = eovf;
        vq.push_back(v);
    endtask

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", n, got, exp);
        end
    endtask

    task automatic chk_all(input string n, input logic eo, input logic [2:0] eid,
                           input logic [2:0] eact, input logic eins, input logic [7:0] eovf);
        chk({n, ".irq_out"},      32'(irq_out),      32'(eo));
        chk({n, ".irq_id"},       32'(irq_id),       32'(eid));
        chk({n, ".active_id"},    32'(active_id),    32'(eact));
        chk({n, ".in_service"},   32'(in_service),   32'(eins));
        chk({n, ".irq_overflow"}, 32'(irq_overflow), 32'(eovf));
    endtask

    localparam logic [7:0] EA = 8'hFF;
    localparam logic [7:0] ED = 8'hBF;

    logic [23:0] pa, pb, pc, pd, pe, pg;

    initial begin
        pa = pr(2, 3);
        pb = pr(1, 2) | pr(5, 6);
        pc = pr(3, 4) | pr(4, 4);
        pd = pr(6, 5);
        pe = pr(0, 1) | pr(7, 7);
        pg = pr(2, 3) | pr(5, 6);

        // Single edge source: assert, claim, complete
        add("a1", 8'h04, EA, pa, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        add("a2", 8'h00, EA, pa, 0, 0, 0, 1, 2, 0, 0, 8'h00);
        add("a3", 8'h00, EA, pa, 0, 0, 0, 1, 2, 0, 0, 8'h00);
        add("a4", 8'h00, EA, pa, 0, 1, 0, 0, 2, 2, 1, 8'h00);
        add("a5", 8'h00, EA, pa, 0, 0, 0, 0, 2, 2, 1, 8'h00);
        add("a6", 8'h00, EA, pa, 0, 0, 1, 0, 2, 2, 0, 8'h00);
        add("a7", 8'h00, EA, pa, 0, 0, 0, 0, 2, 2, 0, 8'h00);
        // Highest priority first, then the lower one re-asserts
        add("b1", 8'h22, EA, pb, 0, 0, 0, 0, 2, 2, 0, 8'h00);
        add("b2", 8'h00, EA, pb, 0, 0, 0, 1, 5, 2, 0, 8'h00);
        add("b3", 8'h00, EA, pb, 0, 1, 0, 0, 5, 5, 1, 8'h00);
        add("b4", 8'h00, EA, pb, 0, 0, 1, 0, 5, 5, 0, 8'h00);
        add("b5", 8'h00, EA, pb, 0, 0, 0, 1, 1, 5, 0, 8'h00);
        add("b6", 8'h00, EA, pb, 0, 1, 0, 0, 1, 1, 1, 8'h00);
        add("b7", 8'h00, EA, pb, 0, 0, 1, 0, 1, 1, 0, 8'h00);
        add("b8", 8'h00, EA, pb, 0, 0, 0, 0, 1, 1, 0, 8'h00);
        // Equal priority tie and threshold boundary
        add("c1", 8'h18, EA, pc, 4, 0, 0, 0, 1, 1, 0, 8'h00);
        add("c2", 8'h00, EA, pc, 4, 0, 0, 0, 1, 1, 0, 8'h00);
        add("c3", 8'h00, EA, pc, 3, 0, 0, 1, 3, 1, 0, 8'h00);
        add("c4", 8'h00, EA, pc, 3, 1, 0, 0, 3, 3, 1, 8'h00);
        add("c5", 8'h00, EA, pc, 3, 0, 1, 0, 3, 3, 0, 8'h00);
        add("c6", 8'h00, EA, pc, 3, 0, 0, 1, 4, 3, 0, 8'h00);
        add("c7", 8'h00, EA, pc, 7, 0, 0, 0, 4, 3, 0, 8'h00);
        add("c8", 8'h00, EA, pc, 3, 0, 0, 1, 4, 3, 0, 8'h00);
        add("c9", 8'h00, EA, pc, 3, 1, 0, 0, 4, 4, 1, 8'h00);
        add("c10", 8'h00, EA, pc, 3, 0, 1, 0, 4, 4, 0, 8'h00);
        add("c11", 8'h00, EA, pc, 3, 0, 0, 0, 4, 4, 0, 8'h00);
        // Level source held, then dropped while asserted
        add("d1", 8'h40, ED, pd, 0, 0, 0, 0, 4, 4, 0, 8'h00);
        add("d2", 8'h40, ED, pd, 0, 0, 0, 1, 6, 4, 0, 8'h00);
        add("d3", 8'h40, ED, pd, 0, 1, 0, 0, 6, 6, 1, 8'h00);
        add("d4", 8'h40, ED, pd, 0, 0, 1, 0, 6, 6, 0, 8'h00);
        add("d5", 8'h40, ED, pd, 0, 0, 0, 1, 6, 6, 0, 8'h00);
        add("d6", 8'h00, ED, pd, 0, 0, 0, 1, 6, 6, 0, 8'h00);
        add("d7", 8'h00, ED, pd, 0, 0, 0, 0, 6, 6, 0, 8'h00);
        add("d8", 8'h00, ED, pd, 0, 0, 0, 0, 6, 6, 0, 8'h00);
        // Overflow, stray claim/complete, edge during service, claim+complete together
        add("e1", 8'h01, EA, pe, 0, 0, 0, 0, 6, 6, 0, 8'h00);
        add("e2", 8'h00, EA, pe, 0, 0, 1, 1, 0, 6, 0, 8'h00);
        add("e3", 8'h01, EA, pe, 0, 0, 1, 1, 0, 6, 0, 8'h01);
        add("e4", 8'h00, EA, pe, 0, 1, 0, 0, 0, 0, 1, 8'h01);
        add("e5", 8'h00, EA, pe, 0, 0, 1, 0, 0, 0, 0, 8'h01);
        add("e6", 8'h00, EA, pe, 0, 1, 0, 0, 0, 0, 0, 8'h01);
        add("e7", 8'h80, EA, pe, 0, 0, 0, 0, 0, 0, 0, 8'h01);
        add("e8", 8'h00, EA, pe, 0, 0, 0, 1, 7, 0, 0, 8'h01);
        add("e9", 8'h00, EA, pe, 0, 1, 0, 0, 7, 7, 1, 8'h01);
        add("e10", 8'h01, EA, pe, 0, 0, 0, 0, 7, 7, 1, 8'h01);
        add("e11", 8'h00, EA, pe, 0, 1, 0, 0, 7, 7, 1, 8'h01);
        add("e12", 8'h00, EA, pe, 0, 0, 1, 0, 7, 7, 0, 8'h01);
        add("e13", 8'h00, EA, pe, 0, 0, 0, 1, 0, 7, 0, 8'h01);
        add("e14", 8'h00, EA, pe, 0, 1, 1, 0, 0, 0, 1, 8'h01);
        add("e15", 8'h00, EA, pe, 0, 0, 1, 0, 0, 0, 0, 8'h01);
        // Priority-0 source never signals
        add("f1", 8'h08, EA, pe, 0, 0, 0, 0, 0, 0, 0, 8'h01);
        add("f2", 8'h00, EA, pe, 0, 0, 0, 0, 0, 0, 0, 8'h01);
        add("f3", 8'h00, EA, pe, 0, 0, 0, 0, 0, 0, 0, 8'h01);
        // Into SERVICE with another source pending, ahead of the reset
        add("g1", 8'h04, EA, pg, 0, 0, 0, 0, 0, 0, 0, 8'h01);
        add("g2", 8'h00, EA, pg, 0, 0, 0, 1, 2, 0, 0, 8'h01);
        add("g3", 8'h00, EA, pg, 0, 1, 0, 0, 2, 2, 1, 8'h01);
        add("g4", 8'h20, EA, pg, 0, 0, 0, 0, 2, 2, 1, 8'h01);
        add("g5", 8'h00, EA, pg, 0, 0, 0, 0, 2, 2, 1, 8'h01);

        rst_n = 1'b0; irq_src = '0; irq_en = 8'hFF; irq_edge = EA;
        irq_prio = '0; threshold = '0; claim = 1'b0; complete = 1'b0;
        #12;
        chk_all("reset", 0, 0, 0, 0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vq[k]) begin
            irq_src = vq[k].src; irq_edge = vq[k].edm; irq_prio = vq[k].prio;
            threshold = vq[k].thr; claim = vq[k].cl; complete = vq[k].cp;
            @(posedge clk);
            @(negedge clk);
            chk_all(vq[k].name, vq[k].e_out, vq[k].e_id, vq[k].e_act, vq[k].e_ins, vq[k].e_ovf);
        end

        // Asynchronous reset mid-SERVICE, well away from any rising edge
        irq_src = '0; claim = 1'b0; complete = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("quiet%0d.irq_out", c), 32'(irq_out), 32'd0);
        end
        chk("quiet.in_service", 32'(in_service), 32'd0);

        irq_src = 8'h04;
        @(negedge clk);
        irq_src = 8'h00;
        @(negedge clk);
        chk("post_rst.irq_out", 32'(irq_out), 32'd1);
        chk("post_rst.irq_id", 32'(irq_id), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/prio_interrupt_controller.md
PRIO_INTERRUPT_CONTROLLER -- requirements
Module: prio_interrupt_controller

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 8, number of interrupt sources (legal range 2..32).
REQ-002 SHALL have parameter PRIO_W, default 3, width of each per-source priority field.
REQ-003 SHALL have parameter ID_W, default $clog2(NUM_IRQ), width of source-ID outputs.
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 SHALL have port: clk  input  1  single clock; all logic is on the rising edge.
REQ-006 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port: irq_src  input  NUM_IRQ  raw sources, synchronous to clk.
REQ-008 SHALL have port: irq_en  input  NUM_IRQ  per-source enable.
REQ-009 SHALL have port: irq_edge  input  NUM_IRQ  per-source mode; 1 = rising-edge, 0 = level.
REQ-010 SHALL have port: irq_prio  input  NUM_IRQ*PRIO_W  per-source priority, with source i at bits [i*PRIO_W +: PRIO_W].
REQ-011 SHALL have port: threshold  input  PRIO_W  minimum priority; only priority > threshold is signalled.
REQ-012 SHALL have port: claim  input  1  single-cycle CPU claim pulse.
REQ-013 SHALL have port: complete  input  1  single-cycle CPU end-of-service pulse.
REQ-014 SHALL have port: irq_out  output  1  registered interrupt request to the CPU.
REQ-015 SHALL have port: irq_id  output  ID_W  registered ID of the signalled source.
REQ-016 SHALL have port: active_id  output  ID_W  ID of the source currently in service.
REQ-017 SHALL have port: in_service  output  1  high from claim until complete.
REQ-018 SHALL have port: irq_overflow  output  NUM_IRQ  sticky flag per source: an edge was lost.

Function
REQ-019 Edge mode: SHALL sample irq_src into a previous-value register; irq_src=1 with previous=0 sets pending[i].
REQ-020 Level mode: pending[i] SHALL equal registered irq_src[i] every cycle; claim does not clear it.
REQ-021 Edge mode: claim of source i SHALL clear pending[i]; a new edge on i in the same cycle SHALL keep it set (set wins).
REQ-022 Edge mode: an edge arriving while pending[i]=1 and not being cleared SHALL set irq_overflow[i].
REQ-023 Eligibility: source i is eligible iff pending[i] & irq_en[i] & (irq_prio[i] > threshold), all comparisons unsigned.
REQ-024 Winner SHALL be the eligible source with the highest priority; on equal priority, the lowest index wins.
REQ-025 Priority 0 SHALL never be signalled; pending and overflow still update.
REQ-026 FSM states SHALL be IDLE, ASSERT and SERVICE.
REQ-027 IDLE: if any source is eligible, SHALL load irq_id <= winner, irq_out <= 1 and go to ASSERT on the next edge.
REQ-028 ASSERT: SHALL recompute the winner each cycle and update irq_id, so a higher-priority arrival replaces the current ID before claim.
REQ-029 ASSERT: if no source is eligible (disabled, level dropped, threshold raised), SHALL set irq_out <= 0 and return to IDLE.
REQ-030 ASSERT with claim=1: SHALL set active_id <= irq_id, in_service <= 1, irq_out <= 0, clear edge pending, and go to SERVICE.
REQ-031 SERVICE: irq_out SHALL stay 0; new events SHALL pend and are not signalled.
REQ-032 SERVICE with complete=1: SHALL set in_service <= 0 and go to IDLE; a pending eligible source re-asserts irq_out 2 cycles after complete.
REQ-033 A claim outside ASSERT SHALL be ignored.
REQ-034 A complete outside SERVICE SHALL be ignored.
REQ-035 Claim and complete in the same ASSERT cycle: SHALL take the claim and ignore the complete.
REQ-036 Latency: an edge at cycle N sets pending at N+1, and irq_out is high at N+2.

Reset
REQ-037 While rst_n=0, SHALL immediately force: state IDLE; irq_out, irq_id, active_id, in_service = 0; pending, previous-sample and irq_overflow = 0.
REQ-038 Reset asserted mid-ASSERT or mid-SERVICE SHALL abandon the transaction, with no residual pending.
REQ-039 irq_overflow SHALL clear only on reset.

Verification (NUM_IRQ=8, PRIO_W=3)
REQ-040 SHALL cover: src2 edge, prio=3, threshold=0 -> irq_out=1, irq_id=2 two cycles later; claim -> in_service=1, active_id=2; complete -> in_service=0, irq_out stays 0.
REQ-041 SHALL cover: src1 prio=2 and src5 prio=6 pulsed in the same cycle -> irq_id=5; after claim and complete -> irq_id=1 re-asserts.
REQ-042 SHALL cover: src3 and src4 both prio=4 -> irq_id=3; with threshold=4 nothing asserts; with threshold=3 it asserts.
REQ-043 SHALL cover: level src6 held high, claim, complete -> re-asserts irq_id=6; dropping src6 while in ASSERT -> irq_out=0 next cycle, state IDLE.
REQ-044 SHALL cover: two src0 edges before claim -> irq_overflow[0]=1, sticky through claim/complete; src0 edge during SERVICE of src7 -> signalled after complete.
REQ-045 SHALL cover: rst_n pulled low in SERVICE -> all outputs 0 asynchronously; after release, no interrupt without a new event.
